// File: rtl/pic_pkg.sv
// Shared types and bit-field constants for the 8259-compatible command decoder.
package pic_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned VEC_W  = 5;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned LVL_W  = 3;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } pic_state_t;

  // ICW1 fields
  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_LTIM = 3;
  localparam int unsigned BIT_D4    = 4;
  localparam int unsigned BIT_D3    = 3;

  // OCW3 fields
  localparam int unsigned OCW3_RIS  = 0;
  localparam int unsigned OCW3_RR   = 1;
  localparam int unsigned OCW3_P    = 2;
  localparam int unsigned OCW3_SMM  = 5;
  localparam int unsigned OCW3_ESMM = 6;

  // OCW2 R,SL,EOI encodings
  localparam logic [CMD_W-1:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [CMD_W-1:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [CMD_W-1:0] OCW2_NOP          = 3'b010;
  localparam logic [CMD_W-1:0] OCW2_SPEC_EOI     = 3'b011;
  localparam logic [CMD_W-1:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [CMD_W-1:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [CMD_W-1:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [CMD_W-1:0] OCW2_ROT_SPEC_EOI = 3'b111;

endpackage

// File: rtl/pic_wr_strobe_sync.sv
// Synchronizes the CPU write strobe, captures the bus byte during the pulse and
// flags a commit on the trailing edge of wr_n.
module pic_wr_strobe_sync
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              a0,
  input  logic [DATA_W-1:0] din,
  output logic              commit,
  output logic              a0_q,
  output logic [DATA_W-1:0] data_q
);

  logic s1, s2, s3;
  logic captured;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      captured <= 1'b0;
      a0_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      s1 <= wr_n;
      s2 <= s1;
      s3 <= s2;
      // A pulse with cs_n high never sets captured, so its commit is dropped
      if (!s1 && !cs_n) begin
        captured <= 1'b1;
        a0_q     <= a0;
        data_q   <= din;
      end else if (commit) begin
        captured <= 1'b0;
      end
    end
  end

  assign commit = s2 & ~s3 & captured;

endmodule

// File: rtl/pic_init_sequencer.sv
// ICW1-ICW4 initialization sequencer and OCW1-OCW3 decoder of the 8259-compatible PIC.
module pic_init_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              a0,
  input  logic [DATA_W-1:0] din,
  output logic              init_done,
  output logic [VEC_W-1:0]  vector_base,
  output logic [DATA_W-1:0] cascade_cfg,
  output logic              single_mode,
  output logic              level_trig,
  output logic              upm,
  output logic              aeoi,
  output logic              master_sel,
  output logic              buf_mode,
  output logic              sfnm,
  output logic [DATA_W-1:0] imr,
  output logic              ocw2_valid,
  output logic [CMD_W-1:0]  ocw2_cmd,
  output logic [LVL_W-1:0]  ocw2_level,
  output logic              read_isr,
  output logic              poll_pulse,
  output logic              special_mask
);

  logic              commit;
  logic              a0_q;
  logic [DATA_W-1:0] data_q;

  pic_wr_strobe_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .a0     (a0),
    .din    (din),
    .commit (commit),
    .a0_q   (a0_q),
    .data_q (data_q)
  );

  pic_state_t        state_q, state_d;
  logic              ic4_q, ic4_d;
  logic              init_done_d, single_mode_d, level_trig_d;
  logic [VEC_W-1:0]  vector_base_d;
  logic [DATA_W-1:0] cascade_cfg_d, imr_d;
  logic [4:0]        icw4_q, icw4_d;
  logic              ocw2_valid_d, read_isr_d, poll_pulse_d, special_mask_d;
  logic [CMD_W-1:0]  ocw2_cmd_d;
  logic [LVL_W-1:0]  ocw2_level_d;

  logic is_icw1, is_ocw2, is_ocw3;
  assign is_icw1 = !a0_q && data_q[BIT_D4];
  assign is_ocw2 = !a0_q && !data_q[BIT_D4] && !data_q[BIT_D3];
  assign is_ocw3 = !a0_q && !data_q[BIT_D4] && data_q[BIT_D3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_UNINIT;
      ic4_q        <= 1'b0;
      init_done    <= 1'b0;
      vector_base  <= '0;
      cascade_cfg  <= '0;
      single_mode  <= 1'b0;
      level_trig   <= 1'b0;
      icw4_q       <= '0;
      imr          <= '0;
      ocw2_valid   <= 1'b0;
      ocw2_cmd     <= '0;
      ocw2_level   <= '0;
      read_isr     <= 1'b0;
      poll_pulse   <= 1'b0;
      special_mask <= 1'b0;
    end else begin
      state_q      <= state_d;
      ic4_q        <= ic4_d;
      init_done    <= init_done_d;
      vector_base  <= vector_base_d;
      cascade_cfg  <= cascade_cfg_d;
      single_mode  <= single_mode_d;
      level_trig   <= level_trig_d;
      icw4_q       <= icw4_d;
      imr          <= imr_d;
      ocw2_valid   <= ocw2_valid_d;
      ocw2_cmd     <= ocw2_cmd_d;
      ocw2_level   <= ocw2_level_d;
      read_isr     <= read_isr_d;
      poll_pulse   <= poll_pulse_d;
      special_mask <= special_mask_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ic4_d          = ic4_q;
    init_done_d    = init_done;
    vector_base_d  = vector_base;
    cascade_cfg_d  = cascade_cfg;
    single_mode_d  = single_mode;
    level_trig_d   = level_trig;
    icw4_d         = icw4_q;
    imr_d          = imr;
    ocw2_valid_d   = 1'b0;
    ocw2_cmd_d     = ocw2_cmd;
    ocw2_level_d   = ocw2_level;
    read_isr_d     = read_isr;
    poll_pulse_d   = 1'b0;
    special_mask_d = special_mask;

    if (commit) begin
      if (is_icw1) begin
        state_d        = ST_WAIT_ICW2;
        ic4_d          = data_q[ICW1_IC4];
        single_mode_d  = data_q[ICW1_SNGL];
        level_trig_d   = data_q[ICW1_LTIM];
        imr_d          = '0;
        special_mask_d = 1'b0;
        read_isr_d     = 1'b0;
        init_done_d    = 1'b0;
        if (!data_q[ICW1_IC4]) icw4_d = '0;
      end else if (a0_q) begin
        unique case (state_q)
          ST_WAIT_ICW2: begin
            vector_base_d = data_q[7:3];
            if (!single_mode) state_d = ST_WAIT_ICW3;
            else if (ic4_q)   state_d = ST_WAIT_ICW4;
            else              state_d = ST_READY;
          end
          ST_WAIT_ICW3: begin
            cascade_cfg_d = data_q;
            state_d       = ic4_q ? ST_WAIT_ICW4 : ST_READY;
          end
          ST_WAIT_ICW4: begin
            icw4_d  = data_q[4:0];
            state_d = ST_READY;
          end
          ST_READY: imr_d = data_q;
          default: ;
        endcase
      end else if (state_q == ST_READY) begin
        // OCW-form bytes are only acted on after initialization
        if (is_ocw2) begin
          ocw2_valid_d = 1'b1;
          ocw2_cmd_d   = data_q[7:5];
          ocw2_level_d = data_q[2:0];
        end else if (is_ocw3) begin
          if (data_q[OCW3_RR])   read_isr_d     = data_q[OCW3_RIS];
          if (data_q[OCW3_ESMM]) special_mask_d = data_q[OCW3_SMM];
          poll_pulse_d = data_q[OCW3_P];
        end
      end
    end

    if (state_d == ST_READY && state_q != ST_READY) init_done_d = 1'b1;
  end

  assign upm        = icw4_q[0];
  assign aeoi       = icw4_q[1];
  assign master_sel = icw4_q[2];
  assign buf_mode   = icw4_q[3];
  assign sfnm       = icw4_q[4];

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed-vector bench for the PIC initialization sequencer and OCW decoder.
module tb_pic_init_sequencer;
  import pic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;

  logic       init_done, single_mode, level_trig, upm, aeoi, master_sel, buf_mode, sfnm;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr;
  logic       ocw2_valid, read_isr, poll_pulse, special_mask;
  logic [2:0] ocw2_cmd, ocw2_level;

  int errors = 0;
  int checks = 0;

  pic_init_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cs_n         (cs_n),
    .wr_n         (wr_n),
    .a0           (a0),
    .din          (din),
    .init_done    (init_done),
    .vector_base  (vector_base),
    .cascade_cfg  (cascade_cfg),
    .single_mode  (single_mode),
    .level_trig   (level_trig),
    .upm          (upm),
    .aeoi         (aeoi),
    .master_sel   (master_sel),
    .buf_mode     (buf_mode),
    .sfnm         (sfnm),
    .imr          (imr),
    .ocw2_valid   (ocw2_valid),
    .ocw2_cmd     (ocw2_cmd),
    .ocw2_level   (ocw2_level),
    .read_isr     (read_isr),
    .poll_pulse   (poll_pulse),
    .special_mask (special_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({init_done, vector_base, cascade_cfg, single_mode, level_trig, upm, aeoi,
                master_sel, buf_mode, sfnm, imr, ocw2_valid, ocw2_cmd, ocw2_level,
                read_isr, poll_pulse, special_mask});
  endfunction

  // One bus write; returns just after the edge where the commit lands
  task automatic wr(input logic cs, input logic a, input logic [7:0] d);
    @(negedge clk);
    cs_n = cs; a0 = a; din = d; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cs_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;

    // single mode, IC4=1: ICW3 skipped, waits for ICW4
    wr(1'b0, 1'b0, 8'h13);
    wr(1'b0, 1'b1, 8'h48);
    check("single_vector_base", 64'(vector_base), 64'h09);
    check("single_mode", 64'(single_mode), 64'd1);
    check("single_wait_icw4", 64'(init_done), 64'd0);
    wr(1'b0, 1'b1, 8'h00);
    check("single_init_done", 64'(init_done), 64'd1);
    check("single_upm", 64'(upm), 64'd0);
    check("single_icw3_skipped", 64'(cascade_cfg), 64'h00);

    // cascaded, full four-word sequence
    wr(1'b0, 1'b0, 8'h11);
    check("casc_icw1_clears_done", 64'(init_done), 64'd0);
    wr(1'b0, 1'b1, 8'h20);
    wr(1'b0, 1'b1, 8'h04);
    check("casc_cfg", 64'(cascade_cfg), 64'h04);
    check("casc_not_done_after_3", 64'(init_done), 64'd0);
    wr(1'b0, 1'b1, 8'h03);
    check("casc_done_after_4", 64'(init_done), 64'd1);
    check("casc_upm", 64'(upm), 64'd1);
    check("casc_aeoi", 64'(aeoi), 64'd1);
    check("casc_single_mode", 64'(single_mode), 64'd0);
    check("casc_vector_base", 64'(vector_base), 64'h04);

    wr(1'b0, 1'b1, 8'hA5);
    check("ocw1_imr", 64'(imr), 64'hA5);
    wr(1'b0, 1'b0, 8'h63);
    check("ocw2_valid_hi", 64'(ocw2_valid), 64'd1);
    check("ocw2_cmd", 64'(ocw2_cmd), 64'(OCW2_SPEC_EOI));
    check("ocw2_level", 64'(ocw2_level), 64'd3);
    @(posedge clk); #1;
    check("ocw2_valid_one_cycle", 64'(ocw2_valid), 64'd0);

    wr(1'b0, 1'b0, 8'h0B);
    check("ocw3_read_isr", 64'(read_isr), 64'd1);
    wr(1'b0, 1'b0, 8'h0C);
    check("ocw3_poll_hi", 64'(poll_pulse), 64'd1);
    check("ocw3_read_isr_held", 64'(read_isr), 64'd1);
    @(posedge clk); #1;
    check("ocw3_poll_one_cycle", 64'(poll_pulse), 64'd0);
    wr(1'b0, 1'b0, 8'h68);
    check("ocw3_special_mask", 64'(special_mask), 64'd1);

    wr(1'b1, 1'b1, 8'h5A);
    check("cs_high_ignored", 64'(imr), 64'hA5);
    wr(1'b0, 1'b1, 8'hFF);
    check("ocw1_imr_ff", 64'(imr), 64'hFF);

    // restart mid-operation
    wr(1'b0, 1'b0, 8'h13);
    check("restart_imr", 64'(imr), 64'h00);
    check("restart_special_mask", 64'(special_mask), 64'd0);
    check("restart_init_done", 64'(init_done), 64'd0);
    check("restart_read_isr", 64'(read_isr), 64'd0);
    check("restart_upm_held", 64'(upm), 64'd1);
    check("restart_vector_held", 64'(vector_base), 64'h04);
    wr(1'b0, 1'b0, 8'h20);
    check("wait_icw2_ocw_ignored", 64'(ocw2_valid), 64'd0);
    check("wait_icw2_cmd_held", 64'(ocw2_cmd), 64'(OCW2_SPEC_EOI));
    wr(1'b0, 1'b1, 8'h48);
    check("restart_vector_base", 64'(vector_base), 64'h09);
    check("restart_still_wait_icw4", 64'(init_done), 64'd0);

    // asynchronous reset between ICW2 and ICW4
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midseq_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    wr(1'b0, 1'b1, 8'hC3);
    check("uninit_ocw1_imr", 64'(imr), 64'h00);
    check("uninit_all_zero", all_outs(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
